serial_addsub: RTL
==================

Name: serial_addsub

Overview:
- Bit-serial N-bit adder/subtractor that sits directly downstream of the combinational half adder/half subtractor cell.
- Extends that single-bit add/subtract with a registered carry/borrow so one bit slice performs multi-bit arithmetic, LSB first, one bit per clock.
- Operands load in parallel; the result is presented in parallel.
- Control uses a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1 to 32.
- CW, 6, bit-counter width; must satisfy 2^CW > WIDTH.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request to begin an operation; sampled on the rising edge.
- op  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start.
- a  input  WIDTH  first operand; sampled with start.
- b  input  WIDTH  second operand; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse when result is valid.
- result  output  WIDTH  sum or difference, modulo 2^WIDTH.
- cout  output  1  final carry (add) or final borrow (sub).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n; it is sampled only on the rising edge of clk.
- Reset values:
  - busy=0, done=0, result=0, cout=0.
  - State = IDLE.
  - Internal operand shift registers, bit counter and carry/borrow flop = 0.
- States:
  - IDLE: busy=0, done=0.
    - Edge with start=1: latch a, b and op; clear the carry/borrow flop; counter=0; go to RUN.
    - Edge with start=0: stay in IDLE.
  - RUN: busy=1, done=0.
    - Each edge processes operand bit 0 of the shifted operand registers, with x=a bit, y=b bit, c=carry/borrow flop.
    - Add: s = x^y^c; c_next = (x&y) | (c&(x^y)).
    - Sub: s = x^y^c; c_next = (~x&y) | (~(x^y)&c).
    - s shifts into the result shift register from the MSB end.
    - Operands shift right by 1; counter increments.
    - On the edge that processes bit WIDTH-1: go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle.
    - On entry: result = completed shift register; cout = final carry/borrow.
    - Next edge: go to IDLE unconditionally.
- Latency:
  - Start accepted on edge T.
  - busy=1 during cycles T+1 .. T+WIDTH.
  - done=1 in the cycle following edge T+WIDTH, for one cycle only.
  - Throughput: one operation per WIDTH+2 cycles.
- Output holding:
  - result and cout hold their last completed value through IDLE, including while the next operation runs.
  - They update only on entry to DONE.
  - The intermediate shift register must not be visible on result.
- Handshake rules:
  - start is ignored in RUN and in DONE; no queuing.
  - a, b and op may change freely after the accepting edge.
- Width and arithmetic rules:
  - result is modulo 2^WIDTH.
  - Add: cout=1 when a+b >= 2^WIDTH.
  - Sub: cout=1 when a < b (unsigned); result is then the two's-complement wrap.
- WIDTH=1: the block reproduces the half adder/half subtractor truth table, with cout = carry or borrow respectively.
- Reset mid-operation: rst_n=0 on any edge aborts immediately. All outputs, including result and cout, return to reset values; no done pulse.
- Simultaneous rst_n=0 and start=1: reset wins; the operation is not accepted.

Test Plan:
- Reset, then add: WIDTH=4, op=0, a=3, b=5, start for one cycle -> busy high 4 cycles; done pulses once; result=8, cout=0; done low afterwards.
- Add overflow and wrap: a=15, b=1, op=0 -> result=0, cout=1. Then a=15, b=15 -> result=14, cout=1.
- Subtract and borrow: op=1, a=5, b=3 -> result=2, cout=0. Then a=3, b=5 -> result=14, cout=1. Then a=0, b=0 -> result=0, cout=0.
- Handshake:
  - Hold start=1 continuously with a=1, b=2, op=0 -> operations complete every WIDTH+2 cycles, result=3 each time.
  - Change a/b mid-RUN (start=1, a=7, b=7) -> current result unaffected (3); the change is not accepted until back in IDLE.
- Reset mid-operation: start a=9, b=4, op=0; assert rst_n=0 on cycle 2 of RUN -> next cycle busy=0, done=0, result=0, cout=0; no done pulse ever appears for the aborted operation.
- WIDTH=1 instance, all four a/b combinations for both ops -> add: result/cout = 0/0, 1/0, 1/0, 0/1; sub: 0/0, 1/1, 1/0, 0/0 for (a,b) = 00, 01, 10, 11.

Source files
------------

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: one bit slice with a registered carry/borrow walks the
// operands LSB first and publishes the parallel result once all WIDTH bits are done.
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int CW    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] sr_q, sr_d, sr_shift;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             op_q, op_d, c_q, c_d, cout_q, cout_d;
    logic             x, y, s, c_next;

    // Single bit slice shared by add and subtract; only the carry term differs.
    assign x      = a_q[0];
    assign y      = b_q[0];
    assign s      = x ^ y ^ c_q;
    assign c_next = op_q ? ((~x & y) | (~(x ^ y) & c_q))
                         : ((x & y) | (c_q & (x ^ y)));

    generate
        if (WIDTH == 1) begin : g_w1
            assign sr_shift = s;
        end else begin : g_wn
            assign sr_shift = {s, sr_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        result_d = result_q;
        cout_d   = cout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sr_d  = sr_shift;
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = c_next;
                cnt_d = cnt_q + CW'(1);
                // Publish on the last bit so the partial shift register never reaches result.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    result_d = sr_shift;
                    cout_d   = c_next;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            sr_q     <= '0;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign cout   = cout_q;

endmodule
